// File: rtl/sha3_sponge_ctrl.sv
// SHA-3 sponge sequencer: absorbs a message stream into the Keccak rate, pads, permutes and hands off to the squeeze serializer.
// Optional hardware pad10*1 insertion is enabled by defining SHA_HW_PAD_EN.
module sha3_sponge_ctrl #(
    parameter int unsigned DATA_WIDTH = 16
) (
    input  logic                  ACLK,
    input  logic                  ARESET,
    input  logic [DATA_WIDTH-1:0] S_TDATA,
    input  logic                  S_TVALID,
    output logic                  S_TREADY,
    input  logic                  S_TLAST,
    input  logic [1:0]            S_TUSER,
    output logic [DATA_WIDTH-1:0] ABS_DATA,
    output logic [7:0]            ABS_IDX,
    output logic                  ABS_WE,
    output logic                  STATE_CLR,
    output logic                  PERM_START,
    input  logic                  PERM_DONE,
    output logic                  OUT_READY,
    output logic [1:0]            OUT_MODE,
    input  logic                  OUT_LAST,
    output logic                  BUSY
);

    localparam int unsigned DW    = DATA_WIDTH;
    localparam int unsigned IDX_W = 8;

`ifdef SHA_HW_PAD_EN
    localparam logic [DW-1:0] PAD_FIRST = DW'(8'h06);
    localparam logic [DW-1:0] PAD_LAST  = DW'(8'h80) << (DW - 8);
    localparam logic [DW-1:0] PAD_BOTH  = PAD_FIRST | PAD_LAST;
`endif

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLR     = 3'd1,
        ST_ABSORB  = 3'd2,
        ST_PERM    = 3'd3,
`ifdef SHA_HW_PAD_EN
        ST_PAD     = 3'd4,
`endif
        ST_SQUEEZE = 3'd5,
        ST_FLUSH   = 3'd6
    } state_t;

    // Rate in words for each digest select.
    function automatic logic [IDX_W-1:0] rate_words(input logic [1:0] sel);
        case (sel)
            2'd0:    return IDX_W'(1152 / DW);
            2'd1:    return IDX_W'(1088 / DW);
            2'd2:    return IDX_W'(832 / DW);
            default: return IDX_W'(576 / DW);
        endcase
    endfunction

    state_t           state;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] rate_m1;
    logic             final_q;
    logic             perm_first;
`ifdef SHA_HW_PAD_EN
    logic             pad_pending;
    logic             pad_phase;
    logic [IDX_W-1:0] pad_k;
`endif

    // Sequencer: every output is registered alongside the state it belongs to.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state       <= ST_IDLE;
            idx         <= '0;
            rate_m1     <= '0;
            final_q     <= 1'b0;
            perm_first  <= 1'b0;
`ifdef SHA_HW_PAD_EN
            pad_pending <= 1'b0;
            pad_phase   <= 1'b0;
            pad_k       <= '0;
`endif
            S_TREADY    <= 1'b0;
            ABS_DATA    <= '0;
            ABS_IDX     <= '0;
            ABS_WE      <= 1'b0;
            STATE_CLR   <= 1'b0;
            PERM_START  <= 1'b0;
            OUT_READY   <= 1'b0;
            OUT_MODE    <= 2'd0;
            BUSY        <= 1'b0;
        end else begin
            STATE_CLR  <= 1'b0;
            PERM_START <= 1'b0;
            ABS_WE     <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (S_TVALID) begin
                        state <= ST_CLR;
                        BUSY  <= 1'b1;
                    end
                end
                ST_CLR: begin
                    STATE_CLR <= 1'b1;
                    OUT_MODE  <= S_TUSER;
                    rate_m1   <= rate_words(S_TUSER) - IDX_W'(1);
                    idx       <= '0;
                    final_q   <= 1'b0;
`ifdef SHA_HW_PAD_EN
                    pad_pending <= 1'b0;
`endif
                    state     <= ST_ABSORB;
                    S_TREADY  <= 1'b1;
                end
                ST_ABSORB: begin
                    if (S_TVALID && S_TREADY) begin
                        ABS_WE   <= 1'b1;
                        ABS_IDX  <= idx;
                        ABS_DATA <= S_TDATA;
                        idx      <= idx + IDX_W'(1);
`ifdef SHA_HW_PAD_EN
                        if (S_TLAST && (idx != rate_m1)) begin
                            state     <= ST_PAD;
                            pad_k     <= idx + IDX_W'(1);
                            pad_phase <= 1'b0;
                            S_TREADY  <= 1'b0;
                        end else if (idx == rate_m1) begin
                            state       <= ST_PERM;
                            perm_first  <= 1'b1;
                            pad_pending <= S_TLAST;
                            pad_k       <= '0;
                            S_TREADY    <= 1'b0;
                        end
`else
                        if (S_TLAST || (idx == rate_m1)) begin
                            state      <= ST_PERM;
                            perm_first <= 1'b1;
                            final_q    <= S_TLAST;
                            S_TREADY   <= 1'b0;
                        end
`endif
                    end
                end
                ST_PERM: begin
                    // A done pulse coinciding with our own start cannot belong to this permutation.
                    if (perm_first) begin
                        PERM_START <= 1'b1;
                        perm_first <= 1'b0;
                    end else if (PERM_DONE && !PERM_START) begin
                        idx <= '0;
                        if (final_q) begin
                            state     <= ST_SQUEEZE;
                            OUT_READY <= 1'b1;
`ifdef SHA_HW_PAD_EN
                        end else if (pad_pending) begin
                            state     <= ST_PAD;
                            pad_phase <= 1'b0;
`endif
                        end else begin
                            state    <= ST_ABSORB;
                            S_TREADY <= 1'b1;
                        end
                    end
                end
`ifdef SHA_HW_PAD_EN
                ST_PAD: begin
                    // Zero pad words are skipped; only the 0x06 and 0x80 words are written.
                    ABS_WE <= 1'b1;
                    if (pad_k == rate_m1) begin
                        ABS_IDX  <= rate_m1;
                        ABS_DATA <= PAD_BOTH;
                    end else if (!pad_phase) begin
                        ABS_IDX  <= pad_k;
                        ABS_DATA <= PAD_FIRST;
                    end else begin
                        ABS_IDX  <= rate_m1;
                        ABS_DATA <= PAD_LAST;
                    end
                    if ((pad_k == rate_m1) || pad_phase) begin
                        state       <= ST_PERM;
                        perm_first  <= 1'b1;
                        final_q     <= 1'b1;
                        pad_pending <= 1'b0;
                    end else begin
                        pad_phase <= 1'b1;
                    end
                end
`endif
                ST_SQUEEZE: begin
                    if (OUT_LAST) begin
                        state     <= ST_FLUSH;
                        OUT_READY <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    state <= ST_IDLE;
                    BUSY  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    S_TREADY  <= 1'b0;
                    OUT_READY <= 1'b0;
                    BUSY      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha3_sponge_ctrl.sv
// Directed bench for sha3_sponge_ctrl at DATA_WIDTH=16; expectations follow SHA_HW_PAD_EN.
module tb_sha3_sponge_ctrl;

    localparam int PERM_LAT = 30;

    logic        ACLK = 1'b0;
    logic        ARESET;
    logic [15:0] S_TDATA;
    logic        S_TVALID;
    logic        S_TREADY;
    logic        S_TLAST;
    logic [1:0]  S_TUSER;
    logic [15:0] ABS_DATA;
    logic [7:0]  ABS_IDX;
    logic        ABS_WE;
    logic        STATE_CLR;
    logic        PERM_START;
    logic        PERM_DONE;
    logic        OUT_READY;
    logic [1:0]  OUT_MODE;
    logic        OUT_LAST;
    logic        BUSY;

    int errors = 0;
    int checks = 0;

    int          cyc = 0;
    int          inject_cyc = -1;
    bit          resp_en = 1'b1;
    int          perm_timer = 0;
    int          wr_n = 0, perm_n = 0, clr_n = 0, tready_bad = 0;
    logic [7:0]  wr_idx  [1024];
    logic [15:0] wr_dat  [1024];
    int          wr_perm [1024];
    int          wr_clr  [1024];

    int          exp_i[$];
    logic [15:0] exp_d[$];
    int          exp_p[$];

    sha3_sponge_ctrl #(.DATA_WIDTH(16)) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .S_TDATA(S_TDATA), .S_TVALID(S_TVALID), .S_TREADY(S_TREADY),
        .S_TLAST(S_TLAST), .S_TUSER(S_TUSER),
        .ABS_DATA(ABS_DATA), .ABS_IDX(ABS_IDX), .ABS_WE(ABS_WE),
        .STATE_CLR(STATE_CLR), .PERM_START(PERM_START), .PERM_DONE(PERM_DONE),
        .OUT_READY(OUT_READY), .OUT_MODE(OUT_MODE), .OUT_LAST(OUT_LAST),
        .BUSY(BUSY)
    );

    always #5 ACLK = ~ACLK;

    // Keccak core model and write logger, sampled on the falling edge.
    initial begin
        PERM_DONE = 1'b0;
        forever begin
            @(negedge ACLK);
            cyc++;
            PERM_DONE = 1'b0;
            if (ABS_WE === 1'b1 && wr_n < 1024) begin
                wr_idx[wr_n]  = ABS_IDX;
                wr_dat[wr_n]  = ABS_DATA;
                wr_perm[wr_n] = perm_n;
                wr_clr[wr_n]  = clr_n;
                wr_n++;
            end
            if (STATE_CLR === 1'b1) clr_n++;
            if (S_TREADY === 1'b1 && perm_timer > 0) tready_bad++;
            if (ARESET) perm_timer = 0;
            else if (PERM_START === 1'b1 && resp_en) perm_timer = PERM_LAT;
            else if (perm_timer > 0) begin
                perm_timer--;
                if (perm_timer == 0) PERM_DONE = 1'b1;
            end
            if (PERM_START === 1'b1) perm_n++;
            if (cyc == inject_cyc) PERM_DONE = 1'b1;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    function automatic logic [15:0] word(input int i);
        return 16'(32'hA000 + i);
    endfunction

    task automatic push_exp(input int i, input logic [15:0] d, input int p);
        exp_i.push_back(i);
        exp_d.push_back(d);
        exp_p.push_back(p);
    endtask

    task automatic push_data(input int n, input int r);
        exp_i.delete(); exp_d.delete(); exp_p.delete();
        for (int i = 0; i < n; i++) push_exp(i % r, word(i), i / r);
    endtask

    task automatic send_msg(input int n, input logic [1:0] tuser, input bit rnd, input logic [15:0] first_data);
        int i = 0;
        int budget = 0;
        bit v;
        S_TUSER = tuser;
        while (i < n && budget < 4000) begin
            @(negedge ACLK);
            budget++;
            if (i >= 1) S_TUSER = ~tuser;
            v = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            S_TVALID = v;
            S_TDATA  = (n == 1) ? first_data : word(i);
            S_TLAST  = (i == n - 1);
            if (v && S_TREADY === 1'b1) i++;
        end
        checks++;
        if (i < n) begin
            errors++;
            $display("FAIL send_timeout accepted=%0d want=%0d", i, n);
        end
        @(negedge ACLK);
        S_TVALID = 1'b0;
        S_TLAST  = 1'b0;
    endtask

    task automatic finish_squeeze(input string name);
        int t = 0;
        while (OUT_READY !== 1'b1 && t < 1000) begin
            @(negedge ACLK);
            t++;
        end
        checks++;
        if (OUT_READY !== 1'b1) begin
            errors++;
            $display("FAIL %s_out_ready_timeout got=%b want=1", name, OUT_READY);
        end
        repeat (3) @(negedge ACLK);
        checks++;
        if (OUT_READY !== 1'b1 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_squeeze_hold got ready=%b busy=%b want ready=1 busy=1", name, OUT_READY, BUSY);
        end
        OUT_LAST = 1'b1;
        @(negedge ACLK);
        OUT_LAST = 1'b0;
        checks++;
        if (OUT_READY !== 1'b0 || BUSY !== 1'b1) begin
            errors++;
            $display("FAIL %s_flush got ready=%b busy=%b want ready=0 busy=1", name, OUT_READY, BUSY);
        end
        @(negedge ACLK);
        checks++;
        if (OUT_READY !== 1'b0 || BUSY !== 1'b0) begin
            errors++;
            $display("FAIL %s_idle got ready=%b busy=%b want ready=0 busy=0", name, OUT_READY, BUSY);
        end
    endtask

    task automatic test_reset();
        ARESET = 1'b1; S_TVALID = 1'b0; S_TLAST = 1'b0; S_TDATA = '0; S_TUSER = 2'd0; OUT_LAST = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++;
        if ({S_TREADY, ABS_WE, STATE_CLR, PERM_START, OUT_READY, BUSY} !== 6'b0) begin
            errors++;
            $display("FAIL reset_strobes got=%b want=000000", {S_TREADY, ABS_WE, STATE_CLR, PERM_START, OUT_READY, BUSY});
        end
        checks++;
        if (ABS_IDX !== 8'd0 || ABS_DATA !== 16'd0 || OUT_MODE !== 2'd0) begin
            errors++;
            $display("FAIL reset_values got idx=%0d data=%h mode=%0d want 0 0 0", ABS_IDX, ABS_DATA, OUT_MODE);
        end
        ARESET = 1'b0;
        repeat (2) @(negedge ACLK);
        checks++;
        if (BUSY !== 1'b0 || S_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle got busy=%b tready=%b want 0 0", BUSY, S_TREADY);
        end
    endtask

    task automatic test_single_word();
        int wb = wr_n, pb = perm_n, cb = clr_n;
        exp_i.delete(); exp_d.delete(); exp_p.delete();
        push_exp(0, 16'h6261, 0);
`ifdef SHA_HW_PAD_EN
        push_exp(1, 16'h0006, 0);
        push_exp(67, 16'h8000, 0);
`endif
        send_msg(1, 2'd1, 1'b0, 16'h6261);
        finish_squeeze("single");
        checks++;
        if (wr_n - wb != exp_i.size()) begin
            errors++;
            $display("FAIL single_count got=%0d want=%0d", wr_n - wb, exp_i.size());
        end
        for (int j = 0; j < exp_i.size() && wb + j < wr_n; j++) begin
            checks++;
            if (wr_idx[wb+j] !== 8'(exp_i[j]) || wr_dat[wb+j] !== exp_d[j] || wr_perm[wb+j] - pb != exp_p[j]) begin
                errors++;
                $display("FAIL single_wr%0d got idx=%0d data=%h blk=%0d want idx=%0d data=%h blk=%0d",
                         j, wr_idx[wb+j], wr_dat[wb+j], wr_perm[wb+j] - pb, exp_i[j], exp_d[j], exp_p[j]);
            end
        end
        checks++;
        if (perm_n - pb != 1 || clr_n - cb != 1) begin
            errors++;
            $display("FAIL single_pulses got perm=%0d clr=%0d want perm=1 clr=1", perm_n - pb, clr_n - cb);
        end
        checks++;
        if (wr_clr[wb] != cb + 1) begin
            errors++;
            $display("FAIL single_clr_before_write got clr_seen=%0d want=%0d", wr_clr[wb] - cb, 1);
        end
        checks++;
        if (OUT_MODE !== 2'd1) begin
            errors++;
            $display("FAIL single_mode got=%0d want=1", OUT_MODE);
        end
    endtask

    task automatic test_full_block();
        int wb = wr_n, pb = perm_n, np;
        push_data(36, 36);
`ifdef SHA_HW_PAD_EN
        push_exp(0, 16'h0006, 1);
        push_exp(35, 16'h8000, 1);
        np = 2;
`else
        np = 1;
`endif
        send_msg(36, 2'd3, 1'b0, 16'h0000);
        finish_squeeze("full");
        checks++;
        if (wr_n - wb != exp_i.size()) begin
            errors++;
            $display("FAIL full_count got=%0d want=%0d", wr_n - wb, exp_i.size());
        end
        for (int j = 0; j < exp_i.size() && wb + j < wr_n; j++) begin
            checks++;
            if (wr_idx[wb+j] !== 8'(exp_i[j]) || wr_dat[wb+j] !== exp_d[j] || wr_perm[wb+j] - pb != exp_p[j]) begin
                errors++;
                $display("FAIL full_wr%0d got idx=%0d data=%h blk=%0d want idx=%0d data=%h blk=%0d",
                         j, wr_idx[wb+j], wr_dat[wb+j], wr_perm[wb+j] - pb, exp_i[j], exp_d[j], exp_p[j]);
            end
        end
        checks++;
        if (perm_n - pb != np || OUT_MODE !== 2'd3) begin
            errors++;
            $display("FAIL full_perm_mode got perm=%0d mode=%0d want perm=%0d mode=3", perm_n - pb, OUT_MODE, np);
        end
    endtask

    task automatic test_last_slot();
        int wb = wr_n, pb = perm_n;
        push_data(71, 72);
`ifdef SHA_HW_PAD_EN
        push_exp(71, 16'h8006, 0);
`endif
        send_msg(71, 2'd0, 1'b0, 16'h0000);
        finish_squeeze("slot");
        checks++;
        if (wr_n - wb != exp_i.size()) begin
            errors++;
            $display("FAIL slot_count got=%0d want=%0d", wr_n - wb, exp_i.size());
        end
        for (int j = 0; j < exp_i.size() && wb + j < wr_n; j++) begin
            checks++;
            if (wr_idx[wb+j] !== 8'(exp_i[j]) || wr_dat[wb+j] !== exp_d[j] || wr_perm[wb+j] - pb != exp_p[j]) begin
                errors++;
                $display("FAIL slot_wr%0d got idx=%0d data=%h blk=%0d want idx=%0d data=%h blk=%0d",
                         j, wr_idx[wb+j], wr_dat[wb+j], wr_perm[wb+j] - pb, exp_i[j], exp_d[j], exp_p[j]);
            end
        end
        checks++;
        if (perm_n - pb != 1 || OUT_MODE !== 2'd0) begin
            errors++;
            $display("FAIL slot_perm_mode got perm=%0d mode=%0d want perm=1 mode=0", perm_n - pb, OUT_MODE);
        end
    endtask

    task automatic test_random_valid();
        int wb = wr_n, pb = perm_n, tb0 = tready_bad;
        push_data(150, 68);
`ifdef SHA_HW_PAD_EN
        push_exp(14, 16'h0006, 2);
        push_exp(67, 16'h8000, 2);
`endif
        send_msg(150, 2'd1, 1'b1, 16'h0000);
        finish_squeeze("rand");
        checks++;
        if (wr_n - wb != exp_i.size()) begin
            errors++;
            $display("FAIL rand_count got=%0d want=%0d", wr_n - wb, exp_i.size());
        end
        for (int j = 0; j < exp_i.size() && wb + j < wr_n; j++) begin
            checks++;
            if (wr_idx[wb+j] !== 8'(exp_i[j]) || wr_dat[wb+j] !== exp_d[j] || wr_perm[wb+j] - pb != exp_p[j]) begin
                errors++;
                $display("FAIL rand_wr%0d got idx=%0d data=%h blk=%0d want idx=%0d data=%h blk=%0d",
                         j, wr_idx[wb+j], wr_dat[wb+j], wr_perm[wb+j] - pb, exp_i[j], exp_d[j], exp_p[j]);
            end
        end
        checks++;
        if (perm_n - pb != 3 || tready_bad - tb0 != 0) begin
            errors++;
            $display("FAIL rand_perm got perm=%0d tready_in_perm=%0d want perm=3 tready_in_perm=0",
                     perm_n - pb, tready_bad - tb0);
        end
    endtask

    task automatic test_reset_mid_perm();
        int pb = perm_n, wb, cb;
        resp_en = 1'b0;
        send_msg(52, 2'd2, 1'b0, 16'h0000);
        repeat (4) @(negedge ACLK);
        checks++;
        if (perm_n - pb != 1 || BUSY !== 1'b1 || S_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL rst_in_perm got perm=%0d busy=%b tready=%b want perm=1 busy=1 tready=0", perm_n - pb, BUSY, S_TREADY);
        end
        ARESET = 1'b1;
        @(negedge ACLK);
        ARESET = 1'b0;
        checks++;
        if ({S_TREADY, ABS_WE, STATE_CLR, PERM_START, OUT_READY, BUSY} !== 6'b0 ||
            ABS_IDX !== 8'd0 || ABS_DATA !== 16'd0 || OUT_MODE !== 2'd0) begin
            errors++;
            $display("FAIL rst_values got strobes=%b idx=%0d data=%h mode=%0d want 000000 0 0 0",
                     {S_TREADY, ABS_WE, STATE_CLR, PERM_START, OUT_READY, BUSY}, ABS_IDX, ABS_DATA, OUT_MODE);
        end
        wb = wr_n;
        inject_cyc = cyc + 2;
        repeat (6) @(negedge ACLK);
        checks++;
        if (BUSY !== 1'b0 || OUT_READY !== 1'b0 || wr_n != wb || S_TREADY !== 1'b0) begin
            errors++;
            $display("FAIL rst_done_ignored got busy=%b ready=%b writes=%0d tready=%b want 0 0 0 0",
                     BUSY, OUT_READY, wr_n - wb, S_TREADY);
        end
        resp_en = 1'b1;
        cb = clr_n;
        wb = wr_n;
        send_msg(1, 2'd1, 1'b0, 16'h1234);
        finish_squeeze("rst_next");
        checks++;
        if (clr_n - cb != 1 || wr_n <= wb || wr_clr[wb] != cb + 1 || wr_idx[wb] !== 8'd0 || wr_dat[wb] !== 16'h1234) begin
            errors++;
            $display("FAIL rst_next_msg got clr=%0d idx=%0d data=%h want clr=1 idx=0 data=1234",
                     clr_n - cb, wr_idx[wb], wr_dat[wb]);
        end
        checks++;
        if (OUT_MODE !== 2'd1) begin
            errors++;
            $display("FAIL rst_next_mode got=%0d want=1", OUT_MODE);
        end
    endtask

    initial begin
        test_reset();
        test_single_word();
        test_full_block();
        test_last_slot();
        test_random_valid();
        test_reset_mid_perm();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sha3_sponge_ctrl.md
# sha3_sponge_ctrl

Sponge sequencer for the SHA-3 core. Accepts a message as an AXI-Stream word sequence and drives absorb writes into the 1600-bit Keccak state. Issues permutation starts, inserts FIPS-202 padding in hardware, and hands the final state to the output serializer (Ready/TUSER/Last) for squeeze. One message in flight at a time.

## Interface
- DATA_WIDTH, 16, stream/absorb word width; legal values 8, 16, 32, 64.

Ports:
- ACLK  in  1  clock; all logic on the rising edge.
- ARESET  in  1  synchronous, active-high reset.
- S_TDATA  in  DATA_WIDTH  message word; byte 0 in bits [7:0].
- S_TVALID  in  1  word valid.
- S_TREADY  out  1  controller accepts word.
- S_TLAST  in  1  last message word.
- S_TUSER  in  2  digest select: 0=224, 1=256, 2=384, 3=512; sampled on the first word only.
- ABS_DATA  out  DATA_WIDTH  word to XOR into the state.
- ABS_IDX  out  8  rate-word index, 0..R-1.
- ABS_WE  out  1  absorb write strobe.
- STATE_CLR  out  1  one-cycle pulse; core zeroes its state.
- PERM_START  out  1  one-cycle pulse; starts one Keccak-f[1600].
- PERM_DONE  in  1  one-cycle pulse from the core.
- OUT_READY  out  1  drives serializer Ready.
- OUT_MODE  out  2  latched digest select; drives serializer TUSER.
- OUT_LAST  in  1  serializer Last.
- BUSY  out  1  high in every state except IDLE.

## Operation
- Rate R in words = rate_bits/DATA_WIDTH. rate_bits = 1152/1088/832/576 for TUSER 0/1/2/3. Examples: DW=16 gives 72/68/52/36; DW=64 gives 18/17/13/9.
- States: IDLE, CLR, ABSORB, PERM, PAD, SQUEEZE, FLUSH.
- IDLE: S_TREADY=0. When S_TVALID=1, move to CLR.
- CLR: 1 cycle. STATE_CLR=1. Latch S_TUSER into OUT_MODE. Index idx=0. Move to ABSORB.
- ABSORB: S_TREADY=1. Each handshake registers ABS_WE=1 with ABS_IDX=idx and ABS_DATA=S_TDATA, then increments idx.
  - Handshake at idx=R-1 without TLAST: move to PERM, final=0.
  - Handshake with TLAST at idx<R-1: move to PAD with k=idx+1.
  - Handshake with TLAST at idx=R-1: move to PERM, pad_pending=1, k=0.
- PERM: S_TREADY=0. PERM_START=1 in the first PERM cycle only. Wait for PERM_DONE. PERM_DONE in the same cycle as PERM_START is ignored. On PERM_DONE, reset idx to 0, then:
  - final=1: go to SQUEEZE.
  - else pad_pending=1: go to PAD.
  - otherwise: go to ABSORB.
- PAD (pad10*1, domain byte 0x06): zero pad words are not written, because XOR with 0 leaves the state unchanged.
  - k<R-1: write idx k = 0x06 in byte 0, then idx R-1 = 0x80 in the top byte. Takes 2 cycles.
  - k=R-1: single write of 0x06 in byte 0 OR 0x80 in the top byte. For DW=8 this value is 0x86.
  - Then go to PERM with final=1 and pad_pending cleared.
- SQUEEZE: OUT_READY=1 until OUT_LAST=1 is sampled, then go to FLUSH.
- FLUSH: 1 cycle with OUT_READY=0, which re-arms the serializer. Then go to IDLE.
- S_TUSER changes after the first word are ignored until the next CLR.

## Timing
- Reset values: S_TREADY=0, ABS_WE=0, ABS_IDX=0, ABS_DATA=0, STATE_CLR=0, PERM_START=0, OUT_READY=0, OUT_MODE=0, BUSY=0. State returns to IDLE; pad_pending and final are cleared.
- ARESET in any state, including PERM or SQUEEZE, takes effect on the next edge. A PERM_DONE in flight is discarded. The state is not cleared until the next CLR.
- ABS_* outputs are registered: one cycle after the handshake or PAD cycle. ABS_WE is high for exactly one cycle per write.
- Handshake to PERM_START: 2 cycles (one ABSORB→PERM transition, then the registered pulse). The last absorb write of a block is always visible before PERM_START.
- Latency from first word to STATE_CLR: 2 cycles. The first ABS_WE never precedes STATE_CLR.
- OUT_MODE stays stable from CLR until the next CLR.
- Throughput: one word per cycle in ABSORB. Back-pressure applies for the whole of CLR, PERM, PAD, SQUEEZE and FLUSH.

## Configuration
- SHA_HW_PAD_EN defined: hardware padding as described under PAD.
- SHA_HW_PAD_EN undefined:
  - PAD state is removed; the software supplies an already-padded message.
  - TLAST at any idx goes directly to PERM with final=1.
  - Unwritten words are left untouched.

## Test plan
- DW=16, TUSER=1, one word 0x6261 with TLAST. Required writes: (0,0x6261), (1,0x0006), (67,0x8000). Exactly one PERM_START. OUT_MODE=1. OUT_READY high until OUT_LAST, then one low cycle, then BUSY=0.
- DW=16, TUSER=3, 36 words, TLAST on the 36th. PERM, then pad writes (0,0x0006) and (35,0x8000), then PERM. Two PERM_START pulses total.
- DW=16, TUSER=0, 71 words with TLAST. Single pad write (71,0x8006), then one final PERM.
- TUSER=1, 150 words with S_TVALID toggling randomly; PERM_DONE returns 30 cycles after each start. S_TREADY=0 for the whole of each PERM. Writes are contiguous in index order with no loss. Three PERM_START pulses total.
- ARESET asserted mid-PERM, then a PERM_DONE pulse. All outputs return to reset values and the pulse is ignored. The next message begins with STATE_CLR.
- SHA_HW_PAD_EN undefined, TUSER=3, 36 words with TLAST. No pad writes. One PERM_START, then SQUEEZE.
